// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the FND digit decoders.
// Produces per-digit BCD codes, leading-zero blank flags and an overflow indication.
module bin_to_bcd_converter #(
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [BIN_WIDTH-1:0]  i_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_overflow
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

    function automatic longint unsigned max_value();
        longint unsigned p = 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint unsigned MaxVal = max_value();
    localparam logic [DIGITS-1:0] BlankReset = {{(DIGITS - 1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    // Assert asynchronously, release synchronously to i_clk.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e                state_q, state_d;
    logic [BIN_WIDTH-1:0]  bin_q, bin_d;
    logic [BcdW-1:0]       scr_q, scr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic [BcdW-1:0]       scr_adj;
    logic [DIGITS-1:0]     blank_calc;
    logic [DIGITS:1]       zero_above;

    always_comb begin
        scr_adj = scr_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is blanked only if it and every more-significant digit are zero.
    always_comb begin
        zero_above         = '0;
        zero_above[DIGITS] = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            zero_above[k] = zero_above[k+1] & (scr_q[4*k +: 4] == 4'd0);
        end
        blank_calc = {zero_above[DIGITS-1:1], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    bin_d   = i_value;
                    scr_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 64'(i_value) > MaxVal;
                    state_d = StShift;
                end
            end
            StShift: begin
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d          = cnt_q + CntW'(1);
                if (cnt_q == CntW'(BIN_WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (ovf_q) begin
                    bcd_d      = {DIGITS{4'ha}};
                    blank_d    = '0;
                    overflow_d = 1'b1;
                end else begin
                    bcd_d      = scr_q;
                    blank_d    = blank_calc;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BlankReset;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign o_busy     = (state_q != StIdle);
    assign o_done     = done_q;
    assign o_bcd      = bcd_q;
    assign o_blank    = blank_q;
    assign o_overflow = overflow_q;

endmodule

// File: doc/bin_to_bcd_converter.md
Name: bin_to_bcd_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It sits between the calculator arithmetic result register and the per-digit BCD-to-FND font decoders. It produces one 4-bit BCD code per FND digit, plus a per-digit blank flag that drives each decoder's active-high blank enable. A start/busy/done handshake lets the calculator control block sequence display updates.

Parameters:
BIN_WIDTH, 14, width of the unsigned binary input (14 covers 0..9999).
DIGITS, 4, number of BCD digits / FND positions produced.

Ports:
i_clk  input  1  system clock, all state updates on its rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_start  input  1  request conversion of i_value; sampled only in IDLE.
i_value  input  BIN_WIDTH  unsigned binary operand, captured on accepted start.
o_busy  output  1  high from the cycle after accepted start until done (inclusive).
o_done  output  1  one-cycle pulse: o_bcd/o_blank/o_overflow valid and updated.
o_bcd  output  4*DIGITS  BCD digits, digit 0 (ones) in [3:0], digit k in [4k+3:4k].
o_blank  output  DIGITS  per-digit blank request (1 = blank), bit k for digit k.
o_overflow  output  1  last conversion exceeded 10^DIGITS-1.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, shift/count registers 0, o_busy=0, o_done=0, o_bcd=0, o_overflow=0, o_blank = all ones except bit 0 = 0 (display shows "0").
- States: IDLE, SHIFT, DONE.
- IDLE: i_start=1 at edge k -> capture i_value into the binary shift register, clear the BCD scratch, count=0, flag overflow if i_value > 10^DIGITS-1, go to SHIFT.
- SHIFT: each cycle, first add 3 to every scratch nibble >= 5. Then shift {scratch, binary} left by 1 (binary MSB enters scratch bit 0). count increments; after BIN_WIDTH shift cycles go to DONE.
- DONE (one cycle): o_done=1 and output registers load the result, then return to IDLE. o_busy is 1 in SHIFT and DONE, 0 in IDLE.
- Latency: start accepted at edge k -> o_done high during the cycle following edge k+BIN_WIDTH+1 (15 cycles for default). Timing is fixed regardless of value, including on overflow.
- Outputs hold the last result between o_done pulses; they never show intermediate scratch values.
- Leading-zero blanking: o_blank[k]=1 iff digit k and all digits above k are 0, for k>=1. o_blank[0] is always 0, so value 0 shows a single "0".
- Overflow: o_overflow=1, all o_bcd nibbles = 4'ha (decimal-point-only font), o_blank all 0. o_overflow clears at the next non-overflow done.
- i_start while busy (SHIFT/DONE): ignored, no queueing; i_value changes while busy have no effect.
- i_start held high continuously: a new conversion is accepted on each IDLE cycle, i.e. back-to-back every BIN_WIDTH+2 cycles.
- Reset mid-conversion: abort immediately, no o_done, outputs return to reset values.
- Scratch width 4*DIGITS; the add-3 applies to all DIGITS nibbles each shift. Input bits beyond 10^DIGITS-1 are handled only by the overflow flag.

Test Plan:
- Reset, then i_value=1234 with i_start for 1 cycle -> o_busy high for 15 cycles, o_done pulse 15 cycles after the start edge; o_bcd=16'h1234, o_blank=4'b0000, o_overflow=0.
- i_value=0 -> o_bcd=16'h0000, o_blank=4'b1110. Then i_value=7 -> o_bcd=16'h0007, o_blank=4'b1110. Then i_value=305 -> o_bcd=16'h0305, o_blank=4'b1000.
- i_value=9999 -> o_bcd=16'h9999, o_blank=0, o_overflow=0. Then i_value=10000 -> o_bcd=16'haaaa, o_blank=0, o_overflow=1, same 15-cycle latency. Then i_value=42 -> o_overflow=0, o_bcd=16'h0042, o_blank=4'b1100.
- Start 1234, then pulse i_start with i_value=5678 at cycle 5 of busy -> single o_done with 16'h1234; no second done until a new start in IDLE.
- Start 8888, assert i_reset_n=0 at cycle 7 -> o_busy=0, o_bcd=0, o_blank=4'b1110 immediately; no o_done. After release, start 56 -> o_bcd=16'h0056.
- Hold i_start=1 with i_value stepping 0..20 -> done every 16 cycles, each result equals the value sampled at its accepted start edge.
